// File: rtl/ram_lsu_pkg.sv
// Shared RAM types: bus operations, access sizes and LSU sequencing states.
// Also holds the alignment rule used when a request is accepted.
package pkg_ram;

  localparam int RAM_ADDRW     = 16;
  localparam int RAM_LONG_SIZE = 32;

  typedef enum logic [1:0] {
    RAM_NOP   = 2'd0,
    RAM_FETCH = 2'd1,
    RAM_STORE = 2'd2
  } ram_op_t;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_WORD = 2'd1,
    RAM_LONG = 2'd2
  } data_type_t;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_ISSUE = 2'd1,
    LSU_WAIT  = 2'd2,
    LSU_ERR   = 2'd3
  } lsu_state_t;

  // Words need an even address, longs a multiple of four; bytes go anywhere.
  function automatic logic is_aligned(input data_type_t data_type, input logic [1:0] lsb);
    case (data_type)
      RAM_WORD: return ~lsb[0];
      RAM_LONG: return (lsb == 2'b00);
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_lsu_if.sv
// RAM bus between a host (the LSU) and the SPRAM device.
// The device returns fetch data one cycle after the RAM_FETCH cycle.
interface if_ram;
  import pkg_ram::*;

  ram_op_t                  op;
  logic [RAM_ADDRW-1:0]     addr;
  data_type_t               data_type;
  logic [RAM_LONG_SIZE-1:0] data_in;
  logic [RAM_LONG_SIZE-1:0] data_out;

  modport dev  (input  op, addr, data_type, data_in, output data_out);
  modport host (output op, addr, data_type, data_in, input  data_out);

endinterface

// File: rtl/ram_lsu_ext.sv
// Combinational 32-bit load extender: trims byte/word loads to their size and
// optionally replicates bit 7 or bit 15 into the upper bits.
module long_ext_sign
  import pkg_ram::*;
(
  input  logic [RAM_LONG_SIZE-1:0] data_in,
  input  data_type_t               data_type,
  input  logic                     sign,
  output logic [RAM_LONG_SIZE-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (data_type)
      RAM_BYTE: data_out = {{24{sign & data_in[7]}}, data_in[7:0]};
      RAM_WORD: data_out = {{16{sign & data_in[15]}}, data_in[15:0]};
      default:  data_out = data_in;
    endcase
  end

endmodule

// File: rtl/ram_lsu.sv
// Load/store unit: accepts one CPU request at a time, rejects misaligned ones,
// sequences the one-cycle SPRAM read latency and returns a registered response.
module ram_lsu
  import pkg_ram::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  data_type_t               req_type,
  input  logic                     req_signed,
  input  logic [RAM_ADDRW-1:0]     req_addr,
  input  logic [RAM_LONG_SIZE-1:0] req_data,
  output logic                     rsp_valid,
  output logic [RAM_LONG_SIZE-1:0] rsp_data,
  output logic                     rsp_err,
  if_ram.host                      ram
);

  lsu_state_t               state;
  lsu_state_t               state_next;
  logic [RAM_ADDRW-1:0]     lat_addr;
  data_type_t               lat_type;
  logic [RAM_LONG_SIZE-1:0] lat_data;
  logic                     lat_store;
  logic                     lat_signed;
  logic [RAM_LONG_SIZE-1:0] ext_data;

  always_ff @(posedge clk) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_next;
  end

  // Request fields are captured at accept so the CPU only has to hold them for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr   <= '0;
      lat_type   <= RAM_LONG;
      lat_data   <= '0;
      lat_store  <= 1'b0;
      lat_signed <= 1'b0;
    end else if (state == LSU_IDLE && req_valid) begin
      lat_addr   <= req_addr;
      lat_type   <= req_type;
      lat_data   <= req_data;
      lat_store  <= req_store;
      lat_signed <= req_signed;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE:
        if (req_valid)
          state_next = is_aligned(req_type, req_addr[1:0]) ? LSU_ISSUE : LSU_ERR;
      LSU_ISSUE: state_next = lat_store ? LSU_IDLE : LSU_WAIT;
      LSU_WAIT:  state_next = LSU_IDLE;
      LSU_ERR:   state_next = LSU_IDLE;
      default:   state_next = LSU_IDLE;
    endcase
  end

  // The op is gated by reset so an ISSUE cycle caught by reset never writes.
  always_comb begin
    req_ready     = (state == LSU_IDLE);
    ram.op        = RAM_NOP;
    if (state == LSU_ISSUE && !rst)
      ram.op = lat_store ? RAM_STORE : RAM_FETCH;
    ram.addr      = lat_addr;
    ram.data_type = lat_type;
    ram.data_in   = lat_data;
  end

  long_ext_sign u_ext (
    .data_in   (ram.data_out),
    .data_type (lat_type),
    .sign      (lat_signed),
    .data_out  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        LSU_ISSUE:
          if (lat_store) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
          end
        LSU_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_data  <= ext_data;
        end
        LSU_ERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_data  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu.sv
// Directed bench for ram_lsu with a byte-addressed SPRAM model on the RAM bus.
// The model returns the four bytes starting at the fetch address, so the LSU must trim loads.
module tb_ram_lsu;
  import pkg_ram::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_store;
  data_type_t               req_type;
  logic                     req_signed;
  logic [RAM_ADDRW-1:0]     req_addr;
  logic [RAM_LONG_SIZE-1:0] req_data;
  logic                     rsp_valid;
  logic [RAM_LONG_SIZE-1:0] rsp_data;
  logic                     rsp_err;

  int tests = 0;
  int fails = 0;
  int op_count = 0;

  if_ram ram_bus ();

  ram_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_type   (req_type),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .ram        (ram_bus.host)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<RAM_ADDRW)-1];

  always @(posedge clk) begin
    if (ram_bus.op == RAM_STORE) begin
      mem[ram_bus.addr] <= ram_bus.data_in[7:0];
      if (ram_bus.data_type != RAM_BYTE)
        mem[ram_bus.addr + 1'b1] <= ram_bus.data_in[15:8];
      if (ram_bus.data_type == RAM_LONG) begin
        mem[ram_bus.addr + 2'd2] <= ram_bus.data_in[23:16];
        mem[ram_bus.addr + 2'd3] <= ram_bus.data_in[31:24];
      end
    end
    if (ram_bus.op == RAM_FETCH)
      ram_bus.data_out <= {mem[ram_bus.addr + 2'd3], mem[ram_bus.addr + 2'd2],
                           mem[ram_bus.addr + 1'b1], mem[ram_bus.addr]};
  end

  always @(posedge clk) begin
    if (ram_bus.op != RAM_NOP) op_count <= op_count + 1;
  end

  // Issues one request from idle and reports the cycle (1 = cycle after accept) of its response.
  task automatic do_req(input logic st, input data_type_t ty, input logic sg,
                        input logic [RAM_ADDRW-1:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_type   = ty;
    req_signed = sg;
    req_addr   = a;
    req_data   = d;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_store  = ~st;
    req_type   = RAM_BYTE;
    req_signed = ~sg;
    req_addr   = ~a;
    req_data   = ~d;
    lat = 0;
    rd  = 32'h0;
    er  = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        rd  = rsp_data;
        er  = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_type = RAM_BYTE; req_signed = 1'b0;
    req_addr = '0; req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
    tests++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_rsp: got valid=%b err=%b expected 0 0", rsp_valid, rsp_err);
    end
    tests++;
    if (rsp_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 00000000", rsp_data); end
    tests++;
    if (ram_bus.op !== RAM_NOP || ram_bus.addr !== 16'h0 || ram_bus.data_type !== RAM_LONG || ram_bus.data_in !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_bus: got op=%0d addr=%h type=%0d din=%h expected 0 0000 2 00000000",
               ram_bus.op, ram_bus.addr, ram_bus.data_type, ram_bus.data_in);
    end
  endtask

  task automatic test_store_fetch_long();
    int lat; logic [31:0] rd; logic er; int ops;
    ops = op_count;
    do_req(1'b1, RAM_LONG, 1'b0, 16'h0010, 32'hDEADBEEF, lat, rd, er);
    tests++;
    if (lat != 2 || rd !== 32'h0 || er !== 1'b0) begin
      fails++; $display("[TB] FAIL store_long: got lat=%0d data=%h err=%b expected 2 00000000 0", lat, rd, er);
    end
    do_req(1'b0, RAM_LONG, 1'b1, 16'h0010, 32'h0, lat, rd, er);
    tests++;
    if (lat != 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      fails++; $display("[TB] FAIL fetch_long: got lat=%0d data=%h err=%b expected 3 deadbeef 0", lat, rd, er);
    end
    tests++;
    if (op_count - ops != 2) begin fails++; $display("[TB] FAIL op_cycles: got %0d expected 2", op_count - ops); end
  endtask

  task automatic test_sign_ext();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, RAM_LONG, 1'b0, 16'h0024, 32'h7F7F7F7F, lat, rd, er);
    do_req(1'b1, RAM_BYTE, 1'b0, 16'h0023, 32'h12345680, lat, rd, er);
    do_req(1'b0, RAM_BYTE, 1'b1, 16'h0023, 32'h0, lat, rd, er);
    tests++;
    if (lat != 3 || rd !== 32'hFFFFFF80) begin
      fails++; $display("[TB] FAIL byte_signed: got lat=%0d data=%h expected 3 ffffff80", lat, rd);
    end
    do_req(1'b0, RAM_BYTE, 1'b0, 16'h0023, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'h00000080) begin fails++; $display("[TB] FAIL byte_unsigned: got %h expected 00000080", rd); end
    do_req(1'b1, RAM_WORD, 1'b0, 16'h0042, 32'hABCD8001, lat, rd, er);
    do_req(1'b0, RAM_WORD, 1'b1, 16'h0042, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'hFFFF8001) begin fails++; $display("[TB] FAIL word_signed: got %h expected ffff8001", rd); end
    do_req(1'b0, RAM_WORD, 1'b0, 16'h0042, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'h00008001) begin fails++; $display("[TB] FAIL word_unsigned: got %h expected 00008001", rd); end
    do_req(1'b0, RAM_LONG, 1'b1, 16'h0024, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'h7F7F7F7F) begin fails++; $display("[TB] FAIL long_no_ext: got %h expected 7f7f7f7f", rd); end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd; logic er; int ops;
    ops = op_count;
    do_req(1'b0, RAM_LONG, 1'b0, 16'h0011, 32'h0, lat, rd, er);
    tests++;
    if (lat != 2 || er !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("[TB] FAIL misalign_long: got lat=%0d err=%b data=%h expected 2 1 00000000", lat, er, rd);
    end
    do_req(1'b1, RAM_WORD, 1'b0, 16'h0041, 32'h5555, lat, rd, er);
    tests++;
    if (lat != 2 || er !== 1'b1) begin
      fails++; $display("[TB] FAIL misalign_word: got lat=%0d err=%b expected 2 1", lat, er);
    end
    @(negedge clk);
    tests++;
    if (rsp_err !== 1'b0) begin fails++; $display("[TB] FAIL err_pulse: got %b expected 0", rsp_err); end
    tests++;
    if (op_count != ops) begin fails++; $display("[TB] FAIL misalign_ops: got %0d expected 0", op_count - ops); end
  endtask

  task automatic test_back_to_back();
    logic        st [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    data_type_t  ty [4] = '{RAM_LONG, RAM_LONG, RAM_BYTE, RAM_WORD};
    logic [15:0] ad [4] = '{16'h0100, 16'h0100, 16'h0101, 16'h0102};
    logic [31:0] dt [4] = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h00001234};
    logic [31:0] ex [4] = '{32'h0, 32'hCAFEF00D, 32'h000000F0, 32'h0};
    int k = 0, busy = 0, n_rsp = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (k < 4) begin
        req_valid = 1'b1; req_store = st[k]; req_type = ty[k];
        req_signed = 1'b0; req_addr = ad[k]; req_data = dt[k];
        tests++;
        if (req_ready !== (busy == 0)) begin
          fails++; $display("[TB] FAIL b2b_ready cyc %0d: got %b expected %b", cyc, req_ready, busy == 0);
        end
        if (busy == 0) begin
          busy = st[k] ? 1 : 2;
          k++;
        end else begin
          busy--;
        end
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (rsp_valid) begin
        tests++;
        if (n_rsp >= 4 || rsp_data !== ex[n_rsp & 3]) begin
          fails++; $display("[TB] FAIL b2b_data #%0d: got %h expected %h", n_rsp, rsp_data, ex[n_rsp & 3]);
        end
        n_rsp++;
      end
    end
    tests++;
    if (n_rsp != 4) begin fails++; $display("[TB] FAIL b2b_count: got %0d expected 4", n_rsp); end
  endtask

  task automatic test_bank_select();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, RAM_LONG, 1'b0, 16'h0000, 32'h12345678, lat, rd, er);
    do_req(1'b1, RAM_LONG, 1'b0, 16'h8000, 32'h87654321, lat, rd, er);
    do_req(1'b0, RAM_LONG, 1'b0, 16'h0000, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'h12345678) begin fails++; $display("[TB] FAIL bank_low: got %h expected 12345678", rd); end
    do_req(1'b0, RAM_LONG, 1'b0, 16'h8000, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'h87654321) begin fails++; $display("[TB] FAIL bank_high: got %h expected 87654321", rd); end
  endtask

  task automatic test_reset_midop();
    int lat; logic [31:0] rd; logic er; int ops; int seen;
    do_req(1'b1, RAM_LONG, 1'b0, 16'h0000, 32'h11111111, lat, rd, er);
    do_req(1'b0, RAM_LONG, 1'b0, 16'h0000, 32'h0, lat, rd, er);
    tests++;
    if (rd !== 32'h11111111) begin fails++; $display("[TB] FAIL prefill: got %h expected 11111111", rd); end
    ops = op_count;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_type = RAM_LONG; req_addr = 16'h0000; req_data = 32'hAAAAAAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (ram_bus.op !== RAM_NOP) begin fails++; $display("[TB] FAIL op_gated: got %0d expected 0", ram_bus.op); end
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'h0 || req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midop_reset_outs: got valid=%b err=%b data=%h ready=%b expected 0 0 00000000 1",
               rsp_valid, rsp_err, rsp_data, req_ready);
    end
    tests++;
    if (ram_bus.addr !== 16'h0 || ram_bus.data_type !== RAM_LONG || ram_bus.data_in !== 32'h0) begin
      fails++;
      $display("[TB] FAIL midop_reset_bus: got addr=%h type=%0d din=%h expected 0000 2 00000000",
               ram_bus.addr, ram_bus.data_type, ram_bus.data_in);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    tests++;
    if (seen != 0 || op_count != ops) begin
      fails++; $display("[TB] FAIL midop_abort: got rsp=%0d ops=%0d expected 0 0", seen, op_count - ops);
    end
    do_req(1'b0, RAM_LONG, 1'b0, 16'h0000, 32'h0, lat, rd, er);
    tests++;
    if (lat != 3 || rd !== 32'h11111111) begin
      fails++; $display("[TB] FAIL post_reset_fetch: got lat=%0d data=%h expected 3 11111111", lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_store_fetch_long();
    test_sign_ext();
    test_misalign();
    test_back_to_back();
    test_bank_select();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
